// File: rtl/d7_pkg.sv
// d7_pkg: shared glyphs, mode encodings and FSM states for the seven-segment display controller
package d7_pkg;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [15:0][6:0] GLYPHS = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  localparam logic [1:0] MODE_HEX  = 2'b00;
  localparam logic [1:0] MODE_UDEC = 2'b01;
  localparam logic [1:0] MODE_SDEC = 2'b10;
  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;
endpackage

// File: rtl/d7_display_ctrl_if.sv
// d7_if: load handshake and display outputs of the seven-segment controller
interface d7_if #(
  parameter int DIGITS = 8,
  parameter int DATA_W = 32
);
  logic                  load;
  logic [1:0]            mode;
  logic [DATA_W-1:0]     data;
  logic                  blank_lz;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [DIGITS*7-1:0]   seg;
  modport master (output load, mode, data, blank_lz, input busy, done, overflow, seg);
  modport slave  (input load, mode, data, blank_lz, output busy, done, overflow, seg);
endinterface

// File: rtl/d7_seg_encoder.sv
// d7_seg_encoder: nibble to seven-segment glyph with dash/blank override and output polarity
module d7_seg_encoder
  import d7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);
  logic [6:0] raw;
  assign raw = dash ? SEG_DASH : blank ? SEG_BLANK : GLYPHS[nib];
  assign seg = ACTIVE_LOW ? raw : ~raw;
endmodule

// File: rtl/d7_display_ctrl.sv
// d7_display_ctrl: renders a value as hex, unsigned or signed decimal on seven-segment digits
module d7_display_ctrl
  import d7_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int DATA_W     = 32,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic rst_n,
  d7_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [6:0] DASH_OUT = ACTIVE_LOW ? SEG_DASH : ~SEG_DASH;
  state_t              state;
  logic [DATA_W-1:0]   shreg;
  logic [BW-1:0]       bcd;
  logic [BW-1:0]       adj;
  logic [BW-1:0]       val;
  logic [CW-1:0]       cnt;
  logic [1:0]          mode_q;
  logic                blank_q;
  logic                neg;
  logic                ovf_acc;
  logic                done_q;
  logic                ovf_q;
  logic [DIGITS*7-1:0] seg_q;
  logic [DIGITS*7-1:0] seg_next;
  logic [DIGITS-1:0]   lz;
  logic [DIGITS-1:0]   dash;
  logic [DIGITS-1:0]   blank;
  logic                is_sgn;
  logic                is_dec;
  logic                hex_ovf;
  logic                ovf_now;
  logic                acc_dec;
  logic                acc_neg;
  assign acc_dec = bus.mode == MODE_UDEC || bus.mode == MODE_SDEC;
  assign acc_neg = bus.mode == MODE_SDEC && bus.data[DATA_W-1];
  assign is_sgn  = mode_q == MODE_SDEC;
  assign is_dec  = mode_q == MODE_UDEC || is_sgn;
  assign val     = is_dec ? bcd : BW'(shreg);
  if (DATA_W > BW) begin : g_hex_wide
    assign hex_ovf = |shreg[DATA_W-1:BW];
  end else begin : g_hex_narrow
    assign hex_ovf = 1'b0;
  end
  // the sign digit leaves one fewer value digit, so a nonzero top BCD nibble is overflow
  assign ovf_now = is_sgn ? ovf_acc || bcd[BW-1 -: 4] != 4'd0 : is_dec ? ovf_acc : hex_ovf;
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    assign adj[4*d +: 4] = bcd[4*d +: 4] >= 4'd5 ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
    assign lz[d]    = val[BW-1:4*d] == '0;
    assign dash[d]  = ovf_now || (d == DIGITS - 1 && is_sgn && neg);
    assign blank[d] = (d == DIGITS - 1 && is_sgn) ? !neg : (d != 0) && blank_q && lz[d];
    d7_seg_encoder #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc (
      .nib   (val[4*d +: 4]),
      .blank (blank[d]),
      .dash  (dash[d]),
      .seg   (seg_next[7*d +: 7])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bcd     <= '0;
      cnt     <= '0;
      mode_q  <= MODE_HEX;
      blank_q <= 1'b0;
      neg     <= 1'b0;
      ovf_acc <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      seg_q   <= {DIGITS{DASH_OUT}};
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.load) begin
          mode_q  <= acc_dec ? bus.mode : MODE_HEX;
          blank_q <= bus.blank_lz;
          neg     <= acc_neg;
          shreg   <= acc_neg ? -bus.data : bus.data;
          bcd     <= '0;
          cnt     <= '0;
          ovf_acc <= 1'b0;
          ovf_q   <= 1'b0;
          state   <= acc_dec ? CONVERT : UPDATE;
        end
        CONVERT: begin
          bcd     <= {adj[BW-2:0], shreg[DATA_W-1]};
          ovf_acc <= ovf_acc | adj[BW-1];
          shreg   <= shreg << 1;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(DATA_W - 1)) state <= UPDATE;
        end
        UPDATE: begin
          seg_q  <= seg_next;
          ovf_q  <= ovf_now;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy     = state != IDLE;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.seg      = seg_q;
endmodule

// File: tb/tb_d7_display_ctrl.sv
// tb_d7_display_ctrl: directed table, corner sequences and randomized model checks for d7_display_ctrl
module tb_d7_display_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  d7_if bus ();
  d7_display_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [6:0] gl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [55:0] ALL_DASH = {8{7'h3F}};
  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [31:0] data;
    logic        blank;
    int          lat;
    string       exp;
    logic        ovf;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] str_seg(input string s);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) begin
      byte c;
      c = s[7-i];
      case (c)
        "-": r[7*i +: 7] = 7'h3F;
        " ": r[7*i +: 7] = 7'h7F;
        "A": r[7*i +: 7] = gl[10];
        "b": r[7*i +: 7] = gl[11];
        "C": r[7*i +: 7] = gl[12];
        "d": r[7*i +: 7] = gl[13];
        "E": r[7*i +: 7] = gl[14];
        "F": r[7*i +: 7] = gl[15];
        default: r[7*i +: 7] = gl[4'(c - "0")];
      endcase
    end
    return r;
  endfunction

  function automatic logic [55:0] model(input logic [1:0] mode, input logic [31:0] data,
                                       input logic blank, output logic ovf);
    longint mag, base, lim, p;
    int m, nd, msd;
    logic neg;
    logic [3:0] dig [8];
    logic [55:0] s;
    m = (mode == 2'b11) ? 0 : int'(mode);
    base = (m == 0) ? 16 : 10;
    nd = (m == 2) ? 7 : 8;
    neg = (m == 2) && data[31];
    mag = neg ? 64'd4294967296 - longint'({32'd0, data}) : longint'({32'd0, data});
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * base;
    ovf = mag >= lim;
    if (ovf) return ALL_DASH;
    msd = 0;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      dig[i] = 4'((mag / p) % base);
      if (i < nd && dig[i] != 0) msd = i;
      p = p * base;
    end
    for (int i = 0; i < 8; i++)
      s[7*i +: 7] = (i >= nd) ? (neg ? 7'h3F : 7'h7F) : (blank && i > msd) ? 7'h7F : gl[dig[i]];
    return s;
  endfunction

  task automatic load_and_wait(input logic [1:0] mode, input logic [31:0] data, input logic blank,
                               input int inject, output int lat);
    bus.mode = mode;
    bus.data = data;
    bus.blank_lz = blank;
    bus.load = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    bus.mode = 2'($urandom);
    bus.data = $urandom;
    bus.blank_lz = 1'($urandom);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      if (n == inject) begin
        bus.load = 1'b1;
        bus.mode = 2'b00;
        bus.data = 32'h87654321;
      end
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run(input string name, input logic [1:0] mode, input logic [31:0] data,
                     input logic blank, input int exp_lat, input logic [55:0] exp_seg,
                     input logic exp_ovf, input int inject);
    int lat;
    logic [55:0] seg_now;
    load_and_wait(mode, data, blank, inject, lat);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " seg"}, 64'(bus.seg), 64'(exp_seg));
    check({name, " overflow"}, 64'(bus.overflow), 64'(exp_ovf));
    check({name, " busy"}, 64'(bus.busy), 64'd0);
    seg_now = bus.seg;
    @(posedge clk);
    #1;
    check({name, " done pulse"}, 64'(bus.done), 64'd0);
    check({name, " hold"}, {7'd0, bus.overflow, bus.seg}, {7'd0, exp_ovf, seg_now});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    bus.load = 1'b0;
    bus.mode = 2'b00;
    bus.data = '0;
    bus.blank_lz = 1'b0;
    rst_n = 1'b0;
    tbl[0]  = '{"udec12345678", 2'b01, 32'd12345678, 1'b0, 33, "12345678", 1'b0};
    tbl[1]  = '{"hexDEADBEEF", 2'b00, 32'hDEADBEEF, 1'b0, 1, "dEAdbEEF", 1'b0};
    tbl[2]  = '{"sdec-42", 2'b10, 32'hFFFFFFD6, 1'b1, 33, "-     42", 1'b0};
    tbl[3]  = '{"udec1e8", 2'b01, 32'd100000000, 1'b0, 33, "--------", 1'b1};
    tbl[4]  = '{"sdec1e7", 2'b10, 32'd10000000, 1'b0, 33, "--------", 1'b1};
    tbl[5]  = '{"udec0", 2'b01, 32'd0, 1'b1, 33, "       0", 1'b0};
    tbl[6]  = '{"mode11", 2'b11, 32'h000000A5, 1'b1, 1, "      A5", 1'b0};
    tbl[7]  = '{"sdecmin", 2'b10, 32'h80000000, 1'b0, 33, "--------", 1'b1};
    tbl[8]  = '{"sdec-9999999", 2'b10, 32'hFF676981, 1'b0, 33, "-9999999", 1'b0};
    tbl[9]  = '{"udec99999999", 2'b01, 32'd99999999, 1'b0, 33, "99999999", 1'b0};
    tbl[10] = '{"hex0", 2'b00, 32'd0, 1'b1, 1, "       0", 1'b0};
    tbl[11] = '{"sdec1234", 2'b10, 32'd1234, 1'b0, 33, " 0001234", 1'b0};
    repeat (3) @(posedge clk);
    #1;
    check("reset seg", 64'(bus.seg), 64'(ALL_DASH));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset seg", 64'(bus.seg), 64'(ALL_DASH));
    check("post-reset flags", {61'd0, bus.busy, bus.done, bus.overflow}, 64'd0);
    foreach (tbl[i])
      run(tbl[i].name, tbl[i].mode, tbl[i].data, tbl[i].blank, tbl[i].lat,
          str_seg(tbl[i].exp), tbl[i].ovf, 0);
    for (int k = 0; k < 150; k++) begin
      logic [1:0] m;
      logic [31:0] d;
      logic b, o;
      logic [55:0] e;
      int sel;
      m = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 4);
      d = sel == 0 ? $urandom : sel == 1 ? 32'($urandom_range(0, 999)) :
          sel == 2 ? -32'($urandom_range(0, 99999)) :
          sel == 3 ? 32'($urandom_range(9999990, 10000010)) :
          32'($urandom_range(99999990, 100000010));
      b = 1'($urandom);
      e = model(m, d, b, o);
      run("random", m, d, b, (m == 2'b01 || m == 2'b10) ? 33 : 1, e, o, 0);
    end
    run("busy-load", 2'b01, 32'd12345678, 1'b0, 33, str_seg("12345678"), 1'b0, 5);
    begin
      bit extra;
      extra = 1'b0;
      for (int n = 0; n < 5; n++) begin
        @(posedge clk);
        #1;
        extra |= bus.done | bus.busy;
      end
      check("busy-load not queued", 64'(extra), 64'd0);
    end
    begin
      bit saw_done;
      bus.mode = 2'b01;
      bus.data = 32'd87654321;
      bus.blank_lz = 1'b0;
      bus.load = 1'b1;
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("pre-reset busy", 64'(bus.busy), 64'd1);
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      check("abort seg", 64'(bus.seg), 64'(ALL_DASH));
      check("abort flags", {61'd0, bus.busy, bus.done, bus.overflow}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(posedge clk);
        #1;
        saw_done |= bus.done | bus.busy;
      end
      check("abort no done", 64'(saw_done), 64'd0);
    end
    run("after-reset", 2'b10, 32'hFFFFFC18, 1'b1, 33, str_seg("-   1000"), 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
